// File: rtl/neuron_param_loader.sv
// Byte-serial parameter loader for one neuron_lif: shadow set filled byte by byte, committed on step.
// Optional checksum byte (state K) enabled by defining PARAM_LOADER_CHECKSUM_EN.
module neuron_param_loader #(
    parameter int unsigned SYNAPSES              = 32,
    parameter int unsigned MEMBRANE_BITS         = $clog2(SYNAPSES) + 2,
    parameter int unsigned THRESHOLD_BITS        = MEMBRANE_BITS - 1,
    parameter int unsigned BATCHNORM_ADDEND_BITS = $clog2(SYNAPSES)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             load_start,
    input  logic [7:0]                       data_in,
    input  logic                             data_valid,
    output logic                             data_ready,
    input  logic                             step,
    output logic [SYNAPSES-1:0]              weights,
    output logic [THRESHOLD_BITS-1:0]        threshold,
    output logic [2:0]                       shift,
    output logic [3:0]                       batchnorm_factor,
    output logic [BATCHNORM_ADDEND_BITS-1:0] batchnorm_addend,
    output logic                             busy,
    output logic                             pending,
    output logic                             params_updated,
    output logic                             load_error
);

    localparam int unsigned WBYTES = SYNAPSES / 8;
    localparam int unsigned CNT_W  = (WBYTES > 3) ? $clog2(WBYTES) : 2;
    localparam logic [CNT_W-1:0] LAST_W = CNT_W'(WBYTES - 1);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(2);
    localparam logic [3:0] FACTOR_RST = 4'b0100;

    if ((SYNAPSES % 8) != 0 || SYNAPSES < 8) begin : g_bad_syn
        $error("SYNAPSES must be a multiple of 8 and at least 8");
    end
    if (THRESHOLD_BITS > 8 || THRESHOLD_BITS >= MEMBRANE_BITS || BATCHNORM_ADDEND_BITS > 8)
    begin : g_bad_width
        $error("threshold/addend width out of range");
    end

`ifdef PARAM_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {StIdle, StW, StC, StK} state_e;
`else
    typedef enum logic [1:0] {StIdle, StW, StC} state_e;
`endif

    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic pending_q, pending_d;
    logic updated_q, updated_d;

    logic [SYNAPSES-1:0]              sh_w_q, sh_w_d;
    logic [THRESHOLD_BITS-1:0]        sh_thr_q, sh_thr_d;
    logic [2:0]                       sh_shift_q, sh_shift_d;
    logic [3:0]                       sh_factor_q, sh_factor_d;
    logic [BATCHNORM_ADDEND_BITS-1:0] sh_add_q, sh_add_d;

    logic [SYNAPSES-1:0]              act_w_q, act_w_d;
    logic [THRESHOLD_BITS-1:0]        act_thr_q, act_thr_d;
    logic [2:0]                       act_shift_q, act_shift_d;
    logic [3:0]                       act_factor_q, act_factor_d;
    logic [BATCHNORM_ADDEND_BITS-1:0] act_add_q, act_add_d;

`ifdef PARAM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;
    logic       err_q, err_d;
`endif

    logic ready;
    logic xfer;
    logic commit;

    assign ready  = (state_q != StIdle);
    // load_start wins over a same-cycle byte and discards any waiting shadow set
    assign xfer   = data_valid & ready & ~load_start;
    assign commit = pending_q & step & ~load_start;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        updated_d    = 1'b0;
        sh_w_d       = sh_w_q;
        sh_thr_d     = sh_thr_q;
        sh_shift_d   = sh_shift_q;
        sh_factor_d  = sh_factor_q;
        sh_add_d     = sh_add_q;
        act_w_d      = act_w_q;
        act_thr_d    = act_thr_q;
        act_shift_d  = act_shift_q;
        act_factor_d = act_factor_q;
        act_add_d    = act_add_q;
`ifdef PARAM_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
        err_d        = err_q;
`endif

        if (commit) begin
            act_w_d      = sh_w_q;
            act_thr_d    = sh_thr_q;
            act_shift_d  = sh_shift_q;
            act_factor_d = sh_factor_q;
            act_add_d    = sh_add_q;
            pending_d    = 1'b0;
            updated_d    = 1'b1;
        end

        if (load_start) begin
            state_d   = StW;
            cnt_d     = '0;
            pending_d = 1'b0;
`ifdef PARAM_LOADER_CHECKSUM_EN
            csum_d    = '0;
            err_d     = 1'b0;
`endif
        end else if (xfer) begin
`ifdef PARAM_LOADER_CHECKSUM_EN
            csum_d = csum_q ^ data_in;
`endif
            case (state_q)
                StW: begin
                    sh_w_d[{cnt_q, 3'b000} +: 8] = data_in;
                    if (cnt_q == LAST_W) begin
                        state_d = StC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StC: begin
                    if (cnt_q == '0) begin
                        sh_shift_d  = data_in[6:4];
                        sh_factor_d = data_in[3:0];
                    end else if (cnt_q == CNT_W'(1)) begin
                        sh_thr_d = data_in[THRESHOLD_BITS-1:0];
                    end else begin
                        sh_add_d = data_in[BATCHNORM_ADDEND_BITS-1:0];
                    end
                    if (cnt_q == LAST_C) begin
                        cnt_d = '0;
`ifdef PARAM_LOADER_CHECKSUM_EN
                        state_d = StK;
`else
                        state_d   = StIdle;
                        pending_d = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef PARAM_LOADER_CHECKSUM_EN
                StK: begin
                    state_d = StIdle;
                    if (data_in == csum_q) begin
                        pending_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            updated_q    <= 1'b0;
            sh_w_q       <= '0;
            sh_thr_q     <= '0;
            sh_shift_q   <= '0;
            sh_factor_q  <= FACTOR_RST;
            sh_add_q     <= '0;
            act_w_q      <= '0;
            act_thr_q    <= '0;
            act_shift_q  <= '0;
            act_factor_q <= FACTOR_RST;
            act_add_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            updated_q    <= updated_d;
            sh_w_q       <= sh_w_d;
            sh_thr_q     <= sh_thr_d;
            sh_shift_q   <= sh_shift_d;
            sh_factor_q  <= sh_factor_d;
            sh_add_q     <= sh_add_d;
            act_w_q      <= act_w_d;
            act_thr_q    <= act_thr_d;
            act_shift_q  <= act_shift_d;
            act_factor_q <= act_factor_d;
            act_add_q    <= act_add_d;
        end
    end

`ifdef PARAM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
            err_q  <= 1'b0;
        end else begin
            csum_q <= csum_d;
            err_q  <= err_d;
        end
    end
    assign load_error = err_q;
`else
    assign load_error = 1'b0;
`endif

    assign data_ready       = ready;
    assign busy             = ready;
    assign pending          = pending_q;
    assign params_updated   = updated_q;
    assign weights          = act_w_q;
    assign threshold        = act_thr_q;
    assign shift            = act_shift_q;
    assign batchnorm_factor = act_factor_q;
    assign batchnorm_addend = act_add_q;

endmodule

// File: tb/tb_neuron_param_loader.sv
// Directed self-checking bench for neuron_param_loader (SYNAPSES = 32).
module tb_neuron_param_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_start = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic        step = 1'b0;
    logic [31:0] weights;
    logic [5:0]  threshold;
    logic [2:0]  shift;
    logic [3:0]  batchnorm_factor;
    logic [4:0]  batchnorm_addend;
    logic        busy;
    logic        pending;
    logic        params_updated;
    logic        load_error;

    int total = 0;
    int bad = 0;

    neuron_param_loader #(.SYNAPSES(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .load_start       (load_start),
        .data_in          (data_in),
        .data_valid       (data_valid),
        .data_ready       (data_ready),
        .step             (step),
        .weights          (weights),
        .threshold        (threshold),
        .shift            (shift),
        .batchnorm_factor (batchnorm_factor),
        .batchnorm_addend (batchnorm_addend),
        .busy             (busy),
        .pending          (pending),
        .params_updated   (params_updated),
        .load_error       (load_error)
    );

    always #5 clk = ~clk;

    // All stimulus changes and samples happen on the falling edge.
    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic put(input logic [7:0] b);
        data_in = b;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    // Full sequence; checksum appended when enabled. step_last raises step with the final byte.
    task automatic send_seq(input logic [31:0] w, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input bit step_last, input bit corrupt);
        logic [7:0] seq [8];
        logic [7:0] x;
        int n;
        seq[0] = w[7:0];  seq[1] = w[15:8]; seq[2] = w[23:16]; seq[3] = w[31:24];
        seq[4] = b0;      seq[5] = b1;      seq[6] = b2;
        x = 8'h00;
        for (int i = 0; i < 7; i++) x = x ^ seq[i];
        seq[7] = corrupt ? (x ^ 8'h01) : x;
`ifdef PARAM_LOADER_CHECKSUM_EN
        n = 8;
`else
        n = 7;
`endif
        for (int i = 0; i < n; i++) begin
            data_in = seq[i];
            data_valid = 1'b1;
            step = step_last && (i == n - 1);
            @(negedge clk);
        end
        data_valid = 1'b0;
        step = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        total++; if (weights !== 32'h0) begin bad++; $display("FAIL reset_weights got=%h want=%h", weights, 32'h0); end
        total++; if (batchnorm_factor !== 4'h4) begin bad++; $display("FAIL reset_factor got=%h want=4", batchnorm_factor); end
        total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", data_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if ({pending, params_updated, load_error} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {pending, params_updated, load_error}); end
        total++; if ({threshold, shift, batchnorm_addend} !== 14'h0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", {threshold, shift, batchnorm_addend}); end
    endtask

    task automatic test_basic_load();
        pulse_start();
        total++; if ({busy, data_ready} !== 2'b11) begin bad++; $display("FAIL load_busy got=%b want=11", {busy, data_ready}); end
        send_seq(32'h44332211, 8'h2B, 8'h15, 8'h1E, 1'b0, 1'b0);
        total++; if ({pending, busy} !== 2'b10) begin bad++; $display("FAIL load_pending got=%b want=10", {pending, busy}); end
        total++; if (weights !== 32'h0 || batchnorm_factor !== 4'h4) begin bad++; $display("FAIL load_precommit got=%h/%h want=0/4", weights, batchnorm_factor); end
        pulse_step();
        total++; if (weights !== 32'h44332211) begin bad++; $display("FAIL load_weights got=%h want=44332211", weights); end
        total++; if (shift !== 3'd2 || batchnorm_factor !== 4'hB) begin bad++; $display("FAIL load_bn got=%h/%h want=2/b", shift, batchnorm_factor); end
        total++; if (threshold !== 6'h15) begin bad++; $display("FAIL load_thr got=%h want=15", threshold); end
        total++; if (batchnorm_addend !== 5'b11110) begin bad++; $display("FAIL load_addend got=%b want=11110", batchnorm_addend); end
        total++; if ({params_updated, pending} !== 2'b10) begin bad++; $display("FAIL load_updated got=%b want=10", {params_updated, pending}); end
        @(negedge clk);
        total++; if (params_updated !== 1'b0) begin bad++; $display("FAIL load_updated_pulse got=%b want=0", params_updated); end
        pulse_step();
        total++; if ({params_updated, weights} !== {1'b0, 32'h44332211}) begin bad++; $display("FAIL idle_step got=%b/%h want=0/44332211", params_updated, weights); end
    endtask

    task automatic test_last_byte_with_step();
        pulse_start();
        send_seq(32'hDDCCBBAA, 8'h35, 8'hC7, 8'h43, 1'b1, 1'b0);
        total++; if ({params_updated, pending} !== 2'b01) begin bad++; $display("FAIL samecycle_nocommit got=%b want=01", {params_updated, pending}); end
        total++; if (weights !== 32'h44332211) begin bad++; $display("FAIL samecycle_active got=%h want=44332211", weights); end
        @(negedge clk);
        total++; if (pending !== 1'b1) begin bad++; $display("FAIL samecycle_hold got=%b want=1", pending); end
        pulse_step();
        total++; if (weights !== 32'hDDCCBBAA || params_updated !== 1'b1) begin bad++; $display("FAIL samecycle_commit got=%h/%b want=ddccbbaa/1", weights, params_updated); end
        total++; if ({shift, batchnorm_factor, threshold, batchnorm_addend} !== {3'd3, 4'h5, 6'h07, 5'h03}) begin bad++; $display("FAIL samecycle_ctrl got=%h", {shift, batchnorm_factor, threshold, batchnorm_addend}); end
    endtask

    task automatic test_restart();
        pulse_start();
        put(8'h01);
        put(8'h02);
        // restart with a byte in the same cycle; that byte must be dropped
        data_in = 8'hEE;
        data_valid = 1'b1;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        data_valid = 1'b0;
        send_seq(32'h12345678, 8'h7F, 8'h3F, 8'h10, 1'b0, 1'b0);
        pulse_step();
        total++; if (weights !== 32'h12345678) begin bad++; $display("FAIL restart_weights got=%h want=12345678", weights); end
        total++; if ({shift, batchnorm_factor, threshold, batchnorm_addend} !== {3'd7, 4'hF, 6'h3F, 5'h10}) begin bad++; $display("FAIL restart_ctrl got=%h", {shift, batchnorm_factor, threshold, batchnorm_addend}); end
    endtask

    task automatic test_discard();
        pulse_start();
        send_seq(32'hCAFEF00D, 8'h11, 8'h22, 8'h03, 1'b0, 1'b0);
        pulse_start();
        total++; if ({pending, busy} !== 2'b01) begin bad++; $display("FAIL discard_flags got=%b want=01", {pending, busy}); end
        pulse_step();
        total++; if ({params_updated, weights} !== {1'b0, 32'h12345678}) begin bad++; $display("FAIL discard_active got=%b/%h want=0/12345678", params_updated, weights); end
    endtask

`ifdef PARAM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        send_seq(32'h0BADBEEF, 8'h12, 8'h21, 8'h05, 1'b0, 1'b1);
        total++; if ({load_error, pending, busy} !== 3'b100) begin bad++; $display("FAIL csum_bad got=%b want=100", {load_error, pending, busy}); end
        pulse_step();
        total++; if ({params_updated, weights} !== {1'b0, 32'h12345678}) begin bad++; $display("FAIL csum_active got=%b/%h want=0/12345678", params_updated, weights); end
        pulse_start();
        total++; if (load_error !== 1'b0) begin bad++; $display("FAIL csum_clear got=%b want=0", load_error); end
        send_seq(32'h0BADBEEF, 8'h12, 8'h21, 8'h05, 1'b0, 1'b0);
        pulse_step();
        total++; if (weights !== 32'h0BADBEEF || load_error !== 1'b0) begin bad++; $display("FAIL csum_good got=%h/%b want=0badbeef/0", weights, load_error); end
    endtask
`endif

    task automatic test_reset_mid_load();
        pulse_start();
        put(8'hA1); put(8'hA2); put(8'hA3); put(8'hA4);
        put(8'h2B);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL midload_busy got=%b want=1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++; if ({busy, data_ready, pending} !== 3'b000) begin bad++; $display("FAIL midload_flags got=%b want=000", {busy, data_ready, pending}); end
        total++; if (weights !== 32'h0 || batchnorm_factor !== 4'h4) begin bad++; $display("FAIL midload_active got=%h/%h want=0/4", weights, batchnorm_factor); end
        total++; if ({threshold, shift, batchnorm_addend, load_error} !== 15'h0) begin bad++; $display("FAIL midload_ctrl got=%h want=0", {threshold, shift, batchnorm_addend, load_error}); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_load();
        test_last_byte_with_step();
        test_restart();
        test_discard();
`ifdef PARAM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
